// File: rtl/karatsuba_seq32.sv
// Sequential 32x32 unsigned Karatsuba multiplier.
// Drives one external 18x18 combinational multiplier three times per operation.
module karatsuba_seq32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [17:0] mul_x,
  output logic [17:0] mul_y,
  input  logic [35:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] p
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    MID,
    SUM,
    OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] a_l;
  logic [15:0] a_h;
  logic [15:0] b_l;
  logic [15:0] b_h;

  logic [35:0] z0;
  logic [35:0] z2;
  logic [35:0] zm;

  logic [16:0] a_sum;
  logic [16:0] b_sum;

  logic [63:0] z0_x;
  logic [63:0] z2_x;
  logic [63:0] zm_x;
  logic [63:0] z_mid;
  logic [63:0] p_nxt;

  // Half sums keep their carry so the middle product stays exact.
  assign a_sum = {1'b0, a_h} + {1'b0, a_l};
  assign b_sum = {1'b0, b_h} + {1'b0, b_l};

  // Partial products are signed so approximation error passes straight through.
  assign z0_x = {{28{z0[35]}}, z0};
  assign z2_x = {{28{z2[35]}}, z2};
  assign zm_x = {{28{zm[35]}}, zm};

  assign z_mid = zm_x - z2_x - z0_x;
  assign p_nxt = (z2_x << 32) + (z_mid << 16) + z0_x;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = LO;
        end
      end
      LO:  state_nxt = HI;
      HI:  state_nxt = MID;
      MID: state_nxt = SUM;
      SUM: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, multiplier sequencing and result load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_l   <= '0;
      a_h   <= '0;
      b_l   <= '0;
      b_h   <= '0;
      z0    <= '0;
      z2    <= '0;
      zm    <= '0;
      mul_x <= '0;
      mul_y <= '0;
      p     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_l   <= a[15:0];
            a_h   <= a[31:16];
            b_l   <= b[15:0];
            b_h   <= b[31:16];
            mul_x <= {2'b00, a[15:0]};
            mul_y <= {2'b00, b[15:0]};
          end
        end
        LO: begin
          z0    <= mul_p;
          mul_x <= {2'b00, a_h};
          mul_y <= {2'b00, b_h};
        end
        HI: begin
          z2    <= mul_p;
          mul_x <= {1'b0, a_sum};
          mul_y <= {1'b0, b_sum};
        end
        MID: begin
          zm <= mul_p;
        end
        SUM: begin
          p <= p_nxt;
        end
        OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_seq32.sv
// Scoreboard bench for karatsuba_seq32.
// Exact or stub external multiplier; directed vectors.
module tb_karatsuba_seq32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [17:0] mul_x;
  logic [17:0] mul_y;
  logic [35:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;

  logic        stub;
  int          cyc;
  int          checks;
  int          errors;
  bit          seen;

  logic [63:0] exp_q[$];
  int          acc_q[$];

  karatsuba_seq32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mul_x    (mul_x),
    .mul_y    (mul_y),
    .mul_p    (mul_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p)
  );

  assign mul_p = stub ? 36'd1 : 36'(mul_x) * 36'(mul_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] pe, input bit keep,
                       input bit push, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    acc = -1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
    end else begin
      acc = cyc;
      if (push) begin
        exp_q.push_back(pe);
        acc_q.push_back(cyc);
      end
      step();
      if (!keep) in_valid = 1'b0;
      a = 32'hDEADBEEF;
      b = 32'hCAFEF00D;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc), 64'(acc_q[0] + 5));
          seen = 1'b1;
        end
        chk("p", p, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int acc1;
    int acc2;
    checks    = 0;
    errors    = 0;
    seen      = 1'b0;
    stub      = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 32'd3;
    b         = 32'd5;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_p", p, 64'd0);
    chk("rst_mul_x", 64'(mul_x), 64'd0);
    chk("rst_mul_y", 64'(mul_y), 64'd0);

    issue(32'h00000003, 32'h00000005, 64'h000000000000000F, 0, 1, acc1);
    wait_done();

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0, 1, acc1);
    step();
    step();
    chk("mid_mul_x", 64'(mul_x), 64'h1FFFE);
    chk("mid_mul_y", 64'(mul_y), 64'h1FFFE);
    wait_done();
    chk("idle_mul_x_hold", 64'(mul_x), 64'h1FFFE);
    chk("idle_p_hold", p, 64'hFFFFFFFE00000001);

    out_ready = 1'b0;
    issue(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, 0, 1, acc1);
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      step();
    end
    out_ready = 1'b1;
    chk("pre_hs_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    wait_done();

    issue(32'h00010000, 32'h00010000, 64'h0000000100000000, 1, 1, acc1);
    issue(32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 0, 1, acc2);
    chk("b2b_interval", 64'(acc2 - acc1), 64'd6);
    wait_done();

    issue(32'h00000007, 32'h00000006, 64'd0, 0, 0, acc1);
    step();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    step();
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("hi_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("hi_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hi_rst_p", p, 64'd0);
    chk("hi_rst_mul_x", 64'(mul_x), 64'd0);
    repeat (8) step();
    issue(32'h00000007, 32'h00000006, 64'h000000000000002A, 0, 1, acc1);
    wait_done();

    issue(32'h80000000, 32'h00000002, 64'h0000000100000000, 0, 1, acc1);
    wait_done();
    issue(32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 0, 1, acc1);
    wait_done();
    issue(32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, 0, 1, acc1);
    wait_done();

    stub = 1'b1;
    issue(32'h12345678, 32'h9ABCDEF0, 64'h00000000FFFF0001, 0, 1, acc1);
    wait_done();
    stub = 1'b0;

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/karatsuba_seq32.md
KARATSUBA_SEQ32 -- requirements
Module: karatsuba_seq32

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits, multiplier port width at 18 bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low. Ports are named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operand pair a,b is valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  32  unsigned multiplicand.
REQ-008 b  input  32  unsigned multiplier.
REQ-009 mul_x  output  18  operand to the external combinational 18x18 approximate multiplier, registered.
REQ-010 mul_y  output  18  second operand to the external multiplier, registered.
REQ-011 mul_p  input  36  product returned by the external multiplier, two's complement.
REQ-012 out_valid  output  1  result p is valid.
REQ-013 out_ready  input  1  downstream accepts p.
REQ-014 p  output  64  Karatsuba result, registered.

Function
REQ-015 The FSM SHALL have the states IDLE, LO, HI, MID, SUM and OUT; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in OUT.
REQ-016 In IDLE with in_valid=1, the next edge SHALL register aL=a[15:0], aH=a[31:16], bL=b[15:0], bH=b[31:16] internally; set mul_x={2'b0,aL}, mul_y={2'b0,bL}; and go to LO. Later changes on a and b SHALL be ignored.
REQ-017 The LO-to-HI edge SHALL capture z0=mul_p and set mul_x={2'b0,aH}, mul_y={2'b0,bH}.
REQ-018 The HI-to-MID edge SHALL capture z2=mul_p and set mul_x={1'b0,aH+aL}, mul_y={1'b0,bH+bL}; the 17-bit sums SHALL carry no truncation.
REQ-019 The MID-to-SUM edge SHALL capture zm=mul_p.
REQ-020 The SUM-to-OUT edge SHALL load p = (Z2<<32) + ((ZM-Z2-Z0)<<16) + Z0 modulo 2^64, where Z* is the corresponding z* sign-extended to 64 bits.
REQ-021 The latency SHALL be exactly 4 edges: an operand pair accepted at edge E0 gives out_valid=1 after edge E4.
REQ-022 The mul_p sampling rule SHALL be: mul_p is sampled at the end of the cycle in which the matching mul_x/mul_y are stable, i.e. the external path is combinational and single-cycle.
REQ-023 In OUT, p and out_valid SHALL hold while out_ready=0; an edge with out_ready=1 SHALL return the FSM to IDLE.
REQ-024 p SHALL retain its last value after the FSM leaves OUT. mul_x/mul_y SHALL retain their last values in IDLE and OUT.
REQ-025 There SHALL be no overlap of operations: the earliest next acceptance is the edge after the output handshake. Minimum issue interval is 6 cycles when out_ready=1 is held.
REQ-026 in_valid in any state other than IDLE SHALL be ignored, with no state change caused.
REQ-027 The exactness rule SHALL be: if mul_p is an exact product, p SHALL equal a*b exactly. Approximation error propagates linearly from mul_p, with no saturation.

Reset
REQ-028 rst_n=0 at an edge SHALL force state=IDLE, out_valid=0, p=0, mul_x=0, mul_y=0, and z0=z2=zm=0 plus the operand registers cleared; in_ready SHALL then be 1.
REQ-029 Reset in any state, including mid-operation, SHALL abandon the operation; no out_valid pulse SHALL follow it.
REQ-030 While rst_n=0, in_valid SHALL be ignored.

Verification
REQ-031 With mul_p driven by an exact combinational model: a=0x00000003, b=0x00000005, out_ready=1 -> p=0x000000000000000F, out_valid 4 edges after acceptance, for one cycle.
REQ-032 Exact model: a=b=0xFFFFFFFF -> mul_x in MID=0x1FFFE, p=0xFFFFFFFE00000001.
REQ-033 Exact model: a=0x12345678, b=0x9ABCDEF0, out_ready=0 for 10 cycles then 1 -> p=0x0B00EA4E242D2080 held stable throughout, in_ready=0 until the cycle after the handshake.
REQ-034 Back-to-back: in_valid held at 1 with two pairs queued and out_ready=1 -> acceptances 6 edges apart, both results correct, second-pair a/b changes during busy ignored.
REQ-035 rst_n=0 for one edge while in HI -> state IDLE, in_ready=1, out_valid stays 0, p=0; a subsequent operation completes correctly.
REQ-036 Stub mul_p=0x000000001 constant -> Z0=Z2=ZM=1, p=(1<<32)-(1<<16)+1=0x00000000FFFF0001.
